ripemd160: RTL

Iterative RIPEMD-160 core for the address-hash path. It takes the 256-bit digest from the `sha256` stage and produces the 160-bit hash160 that the address comparator consumes. It computes one left-line round and one right-line round per clock, so one message takes 80 round cycles plus one finalisation cycle. It supports a single in-flight message and does not queue requests.

---
 rtl/ripemd160_pkg.sv | 68 ++++++
 rtl/ripemd160_f.sv | 24 ++
 rtl/ripemd160.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ripemd160_pkg.sv
// Shared types, constants and index tables for the RIPEMD-160 core.
// Covers the initial chaining values, per-group constants and per-round word/rotate tables.
package ripemd160_pkg;

    typedef enum logic [1:0] {StIdle, StRound, StFinal} state_e;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
    } line_t;

    localparam logic [31:0] HInit [5] = '{
        32'h67452301, 32'hEFCDAB89, 32'h98BADCFE, 32'h10325476, 32'hC3D2E1F0
    };

    localparam logic [31:0] KLeft [5] = '{
        32'h00000000, 32'h5A827999, 32'h6ED9EBA1, 32'h8F1BBCDC, 32'hA953FD4E
    };

    localparam logic [31:0] KRight [5] = '{
        32'h50A28BE6, 32'h5C4DD124, 32'h6D703EF3, 32'h7A6D76E9, 32'h00000000
    };

    localparam logic [3:0] MsgSelL [80] = '{
        0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
        7, 4, 13, 1, 10, 6, 15, 3, 12, 0, 9, 5, 2, 14, 11, 8,
        3, 10, 14, 4, 9, 15, 8, 1, 2, 7, 0, 6, 13, 11, 5, 12,
        1, 9, 11, 10, 0, 8, 12, 4, 13, 3, 7, 15, 14, 5, 6, 2,
        4, 0, 5, 9, 7, 12, 2, 10, 14, 1, 3, 8, 11, 6, 15, 13
    };

    localparam logic [3:0] MsgSelR [80] = '{
        5, 14, 7, 0, 9, 2, 11, 4, 13, 6, 15, 8, 1, 10, 3, 12,
        6, 11, 3, 7, 0, 13, 5, 10, 14, 15, 8, 12, 4, 9, 1, 2,
        15, 5, 1, 3, 7, 14, 6, 9, 11, 8, 12, 2, 10, 0, 4, 13,
        8, 6, 4, 1, 3, 11, 15, 0, 5, 12, 2, 13, 9, 7, 10, 14,
        12, 15, 10, 4, 1, 5, 8, 7, 6, 2, 13, 14, 0, 3, 9, 11
    };

    localparam logic [3:0] RotL [80] = '{
        11, 14, 15, 12, 5, 8, 7, 9, 11, 13, 14, 15, 6, 7, 9, 8,
        7, 6, 8, 13, 11, 9, 7, 15, 7, 12, 15, 9, 11, 7, 13, 12,
        11, 13, 6, 7, 14, 9, 13, 15, 14, 8, 13, 6, 5, 12, 7, 5,
        11, 12, 14, 15, 14, 15, 9, 8, 9, 14, 5, 6, 8, 6, 5, 12,
        9, 15, 5, 11, 6, 8, 13, 12, 5, 12, 13, 14, 11, 8, 5, 6
    };

    localparam logic [3:0] RotR [80] = '{
        8, 9, 9, 11, 13, 15, 15, 5, 7, 7, 8, 11, 14, 14, 12, 6,
        9, 13, 15, 7, 12, 8, 9, 11, 7, 7, 12, 7, 6, 15, 13, 11,
        9, 7, 15, 11, 8, 6, 6, 14, 12, 13, 5, 14, 13, 13, 7, 5,
        15, 5, 8, 11, 14, 14, 6, 14, 6, 9, 12, 9, 12, 5, 15, 8,
        8, 5, 12, 9, 12, 5, 14, 6, 8, 13, 6, 5, 15, 13, 11, 11
    };

    // Round group j/16 is simply the top three bits of the 7-bit counter.
    function automatic logic [2:0] grp(input logic [6:0] j);
        return j[6:4];
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/ripemd160_f.sv
// RIPEMD-160 boolean round function, selected by round group 0..4.
module ripemd160_f
    import ripemd160_pkg::*;
(
    input  logic [2:0]  sel,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [31:0] d,
    output logic [31:0] f
);

    always_comb begin
        f = '0;
        unique case (sel)
            3'd0:    f = b ^ c ^ d;
            3'd1:    f = (b & c) | (~b & d);
            3'd2:    f = (b | ~c) ^ d;
            3'd3:    f = (b & d) | (c & ~d);
            3'd4:    f = b ^ (c | ~d);
            default: f = '0;
        endcase
    end

endmodule

// File: rtl/ripemd160.sv
// Iterative RIPEMD-160 of a 32-byte digest: one left and one right round per clock,
// 80 round cycles plus one finalisation cycle.
module ripemd160
    import ripemd160_pkg::*;
(
    input  logic           clk,
    input  logic           rx_reset_n,
    input  logic           rx_start,
    input  logic [255:0]   rx_hash,
    output logic           tx_busy,
    output logic           tx_done,
    output logic [159:0]   tx_hash160
);

    function automatic logic [31:0] rol(input logic [31:0] x, input logic [3:0] s);
        logic [63:0] t;
        t = {x, x} << s;
        return t[63:32];
    endfunction

    state_e       state_q, state_d;
    logic [6:0]   j_q, j_d;
    logic [31:0]  x_q [16];
    logic [31:0]  x_d [16];
    line_t        left_q, left_d, right_q, right_d;
    logic         done_q, done_d;
    logic [159:0] hash_q, hash_d;

    logic [2:0]   grp_l, grp_r;
    logic [31:0]  f_l, f_r, t_l, t_r;
    logic [31:0]  h_new [5];

    assign grp_l = grp(j_q);
    assign grp_r = 3'd4 - grp_l;

    ripemd160_f u_f_left (
        .sel (grp_l),
        .b   (left_q.b),
        .c   (left_q.c),
        .d   (left_q.d),
        .f   (f_l)
    );

    ripemd160_f u_f_right (
        .sel (grp_r),
        .b   (right_q.b),
        .c   (right_q.c),
        .d   (right_q.d),
        .f   (f_r)
    );

    assign t_l = rol(left_q.a + f_l + x_q[MsgSelL[j_q]] + KLeft[grp_l], RotL[j_q]) + left_q.e;
    assign t_r = rol(right_q.a + f_r + x_q[MsgSelR[j_q]] + KRight[grp_l], RotR[j_q])
                 + right_q.e;

    // Single-block message, so the chaining input is always the initial state.
    assign h_new[0] = HInit[1] + left_q.c + right_q.d;
    assign h_new[1] = HInit[2] + left_q.d + right_q.e;
    assign h_new[2] = HInit[3] + left_q.e + right_q.a;
    assign h_new[3] = HInit[4] + left_q.a + right_q.b;
    assign h_new[4] = HInit[0] + left_q.b + right_q.c;

    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        x_d     = x_q;
        left_d  = left_q;
        right_d = right_q;
        done_d  = done_q;
        hash_d  = hash_q;
        unique case (state_q)
            StIdle: begin
                if (rx_start) begin
                    for (int i = 0; i < 8; i++) begin
                        x_d[i] = bswap(rx_hash[255 - 32 * i -: 32]);
                    end
                    x_d[8]  = 32'h00000080;
                    x_d[9]  = '0;
                    x_d[10] = '0;
                    x_d[11] = '0;
                    x_d[12] = '0;
                    x_d[13] = '0;
                    x_d[14] = 32'h00000100;
                    x_d[15] = '0;
                    left_d  = '{a: HInit[0], b: HInit[1], c: HInit[2], d: HInit[3], e: HInit[4]};
                    right_d = left_d;
                    j_d     = '0;
                    done_d  = 1'b0;
                    state_d = StRound;
                end
            end
            StRound: begin
                left_d  = '{a: left_q.e, b: t_l, c: left_q.b, d: rol(left_q.c, 4'd10),
                            e: left_q.d};
                right_d = '{a: right_q.e, b: t_r, c: right_q.b, d: rol(right_q.c, 4'd10),
                            e: right_q.d};
                j_d     = j_q + 7'd1;
                if (j_q == 7'd79) begin
                    state_d = StFinal;
                end
            end
            StFinal: begin
                hash_d  = {bswap(h_new[0]), bswap(h_new[1]), bswap(h_new[2]),
                           bswap(h_new[3]), bswap(h_new[4])};
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rx_reset_n) begin
        if (!rx_reset_n) begin
            state_q <= StIdle;
            j_q     <= '0;
            for (int i = 0; i < 16; i++) begin
                x_q[i] <= '0;
            end
            left_q  <= '0;
            right_q <= '0;
            done_q  <= 1'b0;
            hash_q  <= '0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            x_q     <= x_d;
            left_q  <= left_d;
            right_q <= right_d;
            done_q  <= done_d;
            hash_q  <= hash_d;
        end
    end

    assign tx_busy    = (state_q != StIdle);
    assign tx_done    = done_q;
    assign tx_hash160 = hash_q;

endmodule
